raw10_pack_lane4: RTL and testbench

Transmit-side RAW10 packer: takes one 10-bit pixel per clock with frame/line valid and packs pixels into the MIPI CSI-2 RAW10 byte format. It emits a 4-lane (32-bit) byte-stream word with byte enables. It sits ahead of the CSI-2 TX packet/lane logic and is the inverse of the 4-lane RAW10 unpacker on the receive path. One clock domain; no pixclk/byteclk crossing inside this block.

---
 rtl/raw10_pack_lane4.sv | 227 ++++++++++++++++++++++
 tb/tb_raw10_pack_lane4.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/raw10_pack_lane4.sv
// raw10_pack_lane4
// Packs one 10-bit RAW10 pixel per clock into the CSI-2 RAW10 byte stream and
// presents it as 4-byte words with byte enables. Groups of 4 pixels become
// 5 bytes (four MSB bytes, then one byte of packed LSB pairs). An 8-byte
// accumulator retimes the 5-byte groups onto the 4-byte output word; a
// partial word is flushed while the line is idle.
module raw10_pack_lane4 #(
  parameter int bus_width  = 10,
  parameter int lane_width = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [bus_width-1:0]      pixdata,
  input  logic                      fv,
  input  logic                      lv,
  output logic [8*lane_width-1:0]   dout,
  output logic [lane_width-1:0]     byte_en,
  output logic                      fv_8bit,
  output logic                      lv_8bit
);

  // ---------------------------------------------------------------------------
  // Group collector state
  // ---------------------------------------------------------------------------
  logic [1:0]           idx_q, idx_d;
  logic [bus_width-1:0] pix_q [3];
  logic [bus_width-1:0] pix_d [3];

  // ---------------------------------------------------------------------------
  // Byte accumulator state (stream order, byte 0 is oldest)
  // ---------------------------------------------------------------------------
  logic [7:0] acc_q [8];
  logic [7:0] acc_d [8];
  logic [3:0] count_q, count_d;

  // Registered outputs
  logic [8*lane_width-1:0] dout_q, dout_d;
  logic [lane_width-1:0]   byte_en_q, byte_en_d;
  logic                    lv_8bit_q, lv_8bit_d;

  // Frame-valid delay line
  logic [3:0] fv_sr_q, fv_sr_d;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  logic accept;
  logic push_full;
  logic push_part;
  logic push;

  assign accept    = fv & lv;
  // The 4th accepted pixel completes the group without being stored.
  assign push_full = accept & (idx_q == 2'd3);
  // A line that ended mid-group is zero-padded on its first idle cycle.
  assign push_part = ~lv & (idx_q != 2'd0);
  assign push      = push_full | push_part;

  // ---------------------------------------------------------------------------
  // Group assembly: the 4 pixels of the group being pushed, with pixel slots
  // that were never filled (partial group) forced to zero.
  // ---------------------------------------------------------------------------
  logic [bus_width-1:0] grp_px [4];
  logic [7:0]           grp_byte [5];

  // Select the stored pixels that belong to the group, zeroing stale slots
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      grp_px[k] = '0;
      if (push_full || (2'(k) < idx_q)) begin
        grp_px[k] = pix_q[k];
      end
    end
    grp_px[3] = push_full ? pixdata : '0;
  end

  // RAW10 byte mapping: four MSB bytes, then the LSB pairs with P0 in bits 1:0
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      grp_byte[k] = grp_px[k][9:2];
    end
    grp_byte[4] = {grp_px[3][1:0], grp_px[2][1:0], grp_px[1][1:0], grp_px[0][1:0]};
  end

  // Collector next state: store pixels 0..2, clear the index on completion
  // or when the line goes idle
  always_comb begin
    idx_d = idx_q;
    for (int k = 0; k < 3; k++) begin
      pix_d[k] = pix_q[k];
    end
    if (accept) begin
      if (idx_q == 2'd3) begin
        idx_d = 2'd0;
      end else begin
        pix_d[idx_q] = pixdata;
        idx_d        = idx_q + 2'd1;
      end
    end else if (!lv) begin
      idx_d = 2'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulator merge: existing bytes followed by the pushed group bytes.
  // The count is at most 3 when a push happens, so 8 bytes always suffice.
  // Slots beyond the valid length read as zero, which yields the zero pad on
  // flush words for free.
  // ---------------------------------------------------------------------------
  logic [7:0] ext [8];
  logic [3:0] new_count;
  logic       emit;
  logic       flush;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_ext
      logic [3:0] rel;
      assign rel = 4'(gi) - count_q;
      // Each merged slot is either an old byte, a new group byte, or empty
      always_comb begin
        ext[gi] = 8'h00;
        if (4'(gi) < count_q) begin
          ext[gi] = acc_q[gi];
        end else if (push && (rel < 4'd5)) begin
          ext[gi] = grp_byte[rel[2:0]];
        end
      end
    end
  endgenerate

  assign new_count = count_q + (push ? 4'd5 : 4'd0);
  assign emit      = (new_count >= 4'd4);
  // Only reachable with no push, so new_count == count_q here.
  assign flush     = ~lv & ~push & (count_q != 4'd0) & (count_q < 4'd4);

  // Emit a full word, flush a residual word, or just absorb the push
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      acc_d[k] = ext[k];
    end
    count_d   = new_count;
    dout_d    = '0;
    byte_en_d = '0;
    lv_8bit_d = 1'b0;
    if (emit) begin
      dout_d    = {ext[3], ext[2], ext[1], ext[0]};
      byte_en_d = 4'b1111;
      lv_8bit_d = 1'b1;
      for (int k = 0; k < 4; k++) begin
        acc_d[k]     = ext[k+4];
        acc_d[k+4]   = 8'h00;
      end
      count_d = new_count - 4'd4;
    end else if (flush) begin
      dout_d    = {ext[3], ext[2], ext[1], ext[0]};
      lv_8bit_d = 1'b1;
      case (count_q)
        4'd1:    byte_en_d = 4'b0001;
        4'd2:    byte_en_d = 4'b0011;
        default: byte_en_d = 4'b0111;
      endcase
      for (int k = 0; k < 8; k++) begin
        acc_d[k] = 8'h00;
      end
      count_d = 4'd0;
    end
  end

  // Frame valid shifted along so it brackets the delayed word stream
  always_comb begin
    fv_sr_d = {fv_sr_q[2:0], fv};
  end

  // ---------------------------------------------------------------------------
  // State registers; reset discards any buffered pixels and bytes
  // ---------------------------------------------------------------------------
  // Collector registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_q <= 2'd0;
      for (int k = 0; k < 3; k++) begin
        pix_q[k] <= '0;
      end
    end else begin
      idx_q <= idx_d;
      for (int k = 0; k < 3; k++) begin
        pix_q[k] <= pix_d[k];
      end
    end
  end

  // Accumulator registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= 4'd0;
      for (int k = 0; k < 8; k++) begin
        acc_q[k] <= 8'h00;
      end
    end else begin
      count_q <= count_d;
      for (int k = 0; k < 8; k++) begin
        acc_q[k] <= acc_d[k];
      end
    end
  end

  // Output and frame-valid registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_q    <= '0;
      byte_en_q <= '0;
      lv_8bit_q <= 1'b0;
      fv_sr_q   <= 4'd0;
    end else begin
      dout_q    <= dout_d;
      byte_en_q <= byte_en_d;
      lv_8bit_q <= lv_8bit_d;
      fv_sr_q   <= fv_sr_d;
    end
  end

  assign dout    = dout_q;
  assign byte_en = byte_en_q;
  assign lv_8bit = lv_8bit_q;
  assign fv_8bit = fv_sr_q[3];

endmodule

// File: tb/tb_raw10_pack_lane4.sv
// tb_raw10_pack_lane4
// Scoreboard bench: each line's expected words are built from a line-level
// RAW10 packing model and queued before the pixels are driven; a negedge
// monitor pops and compares every word the packer produces.
module tb_raw10_pack_lane4;

  logic        clk;
  logic        rstn;
  logic [9:0]  pixdata;
  logic        fv;
  logic        lv;
  logic [31:0] dout;
  logic [3:0]  byte_en;
  logic        fv_8bit;
  logic        lv_8bit;

  raw10_pack_lane4 #(.bus_width(10), .lane_width(4)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .pixdata (pixdata),
    .fv      (fv),
    .lv      (lv),
    .dout    (dout),
    .byte_en (byte_en),
    .fv_8bit (fv_8bit),
    .lv_8bit (lv_8bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [35:0] exp_q[$];
  int          pulse_cyc[$];
  logic [3:0]  fv_hist;

  logic [9:0]  line_px [32];
  int          line_words;
  int          l_cyc;
  int          p3_cyc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference history of fv: fv_8bit must equal fv from 4 cycles earlier
  always @(posedge clk or negedge rstn) begin
    if (!rstn) fv_hist <= 4'd0;
    else       fv_hist <= {fv_hist[2:0], fv};
  end

  // Output monitor
  always @(negedge clk) begin
    if (lv_8bit) begin
      check_eq("word_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        logic [35:0] e;
        e = exp_q.pop_front();
        check_eq("dout", 64'(dout), 64'(e[31:0]));
        check_eq("byte_en", 64'(byte_en), 64'(e[35:32]));
      end
      check_eq("lv_inside_fv", 64'(fv_8bit), 64'd1);
      pulse_cyc.push_back(cyc);
      $display("word cyc=%0d dout=0x%08h byte_en=%b", cyc, dout, byte_en);
    end else begin
      check_eq("idle_dout", 64'(dout), 64'd0);
      check_eq("idle_byte_en", 64'(byte_en), 64'd0);
    end
    check_eq("fv_8bit", 64'(fv_8bit), 64'(fv_hist[3]));
  end

  // Line-level model: pad to whole groups, map to bytes, cut into words
  task automatic model_line(input int n);
    logic [7:0] bytes[$];
    logic [9:0] p [4];
    logic [31:0] w;
    logic [3:0]  be;
    line_words = 0;
    for (int g = 0; g < (n + 3) / 4; g++) begin
      for (int j = 0; j < 4; j++) p[j] = (4*g + j < n) ? line_px[4*g + j] : 10'd0;
      for (int j = 0; j < 4; j++) bytes.push_back(p[j][9:2]);
      bytes.push_back({p[3][1:0], p[2][1:0], p[1][1:0], p[0][1:0]});
    end
    for (int s = 0; s < bytes.size(); s += 4) begin
      w = 32'd0;
      be = 4'd0;
      for (int b = 0; b < 4; b++) begin
        if (s + b < bytes.size()) begin
          w[8*b +: 8] = bytes[s + b];
          be[b] = 1'b1;
        end
      end
      exp_q.push_back({be, w});
      line_words++;
    end
  endtask

  // Drive one line of n pixels, then 5 idle cycles; check word count and timing
  task automatic send_line(input int n, input logic fv_lvl, input string tag);
    int base;
    base = pulse_cyc.size();
    if (fv_lvl) model_line(n);
    else        line_words = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == 3) p3_cyc = cyc;
      pixdata = line_px[i];
      lv = 1'b1;
    end
    @(posedge clk); #1;
    lv = 1'b0;
    pixdata = 10'd0;
    l_cyc = cyc;
    repeat (5) @(posedge clk);
    #1;
    check_eq({tag, "_nwords"}, 64'(pulse_cyc.size() - base), 64'(line_words));
    if (line_words > 0 && pulse_cyc.size() > base) begin
      check_eq({tag, "_last_le_L2"}, 64'(pulse_cyc[pulse_cyc.size()-1] <= l_cyc + 2), 64'd1);
      check_eq({tag, "_last_ge_L"}, 64'(pulse_cyc[pulse_cyc.size()-1] >= l_cyc), 64'd1);
    end
  endtask

  initial begin
    int base;
    rstn = 1'b0; fv = 1'b0; lv = 1'b0; pixdata = 10'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_dout", 64'(dout), 64'd0);
    check_eq("rst_byte_en", 64'(byte_en), 64'd0);
    check_eq("rst_lv_8bit", 64'(lv_8bit), 64'd0);
    check_eq("rst_fv_8bit", 64'(fv_8bit), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Test 1: 16-pixel ramp
    fv = 1'b1;
    for (int i = 0; i < 16; i++) line_px[i] = 10'((i * 64 + i) & 10'h3ff);
    base = pulse_cyc.size();
    send_line(16, 1'b1, "ramp16");
    if (pulse_cyc.size() >= base + 5) begin
      check_eq("ramp16_word0_latency", 64'(pulse_cyc[base]), 64'(p3_cyc + 1));
      check_eq("ramp16_w3_w4_consec", 64'(pulse_cyc[base+4]), 64'(pulse_cyc[base+3] + 1));
    end else begin
      check_eq("ramp16_have_5_words", 64'(pulse_cyc.size() - base), 64'd5);
    end

    // Test 2: 4 pixels, full word then single-byte flush on the next cycle
    line_px[0] = 10'h3FF; line_px[1] = 10'h000; line_px[2] = 10'h2AA; line_px[3] = 10'h155;
    base = pulse_cyc.size();
    send_line(4, 1'b1, "px4");
    if (pulse_cyc.size() >= base + 2)
      check_eq("px4_flush_next_cycle", 64'(pulse_cyc[base+1]), 64'(pulse_cyc[base] + 1));

    // Test 3: 6 pixels, partial group pushed at L
    for (int i = 0; i < 6; i++) line_px[i] = 10'($urandom_range(0, 1023));
    send_line(6, 1'b1, "px6");
    fv = 1'b0;
    repeat (6) @(posedge clk); #1;

    // Test 4: a frame of two 16-pixel lines
    base = pulse_cyc.size();
    fv = 1'b1;
    @(posedge clk); #1;
    for (int ln = 0; ln < 2; ln++) begin
      for (int i = 0; i < 16; i++) line_px[i] = 10'($urandom_range(0, 1023));
      send_line(16, 1'b1, "frame_line");
    end
    fv = 1'b0;
    repeat (6) @(posedge clk); #1;
    check_eq("frame_pulses", 64'(pulse_cyc.size() - base), 64'd10);

    // Test 5: reset mid-line after 2 pixels
    fv = 1'b1;
    repeat (5) @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      pixdata = 10'($urandom_range(0, 1023));
      lv = 1'b1;
      @(posedge clk); #1;
    end
    lv = 1'b0;
    pixdata = 10'd0;
    check_eq("pre_reset_fv_8bit", 64'(fv_8bit), 64'd1);
    rstn = 1'b0;
    #1;
    check_eq("mid_rst_dout", 64'(dout), 64'd0);
    check_eq("mid_rst_byte_en", 64'(byte_en), 64'd0);
    check_eq("mid_rst_lv_8bit", 64'(lv_8bit), 64'd0);
    check_eq("mid_rst_fv_8bit", 64'(fv_8bit), 64'd0);
    repeat (2) @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    line_px[0] = 10'h123; line_px[1] = 10'h2F0; line_px[2] = 10'h0AB; line_px[3] = 10'h3C4;
    send_line(4, 1'b1, "post_rst");
    fv = 1'b0;
    repeat (6) @(posedge clk); #1;

    // Test 6: lv high with fv low must produce nothing
    base = pulse_cyc.size();
    for (int i = 0; i < 8; i++) line_px[i] = 10'($urandom_range(0, 1023));
    send_line(8, 1'b0, "fv_low");
    check_eq("fv_low_no_pulses", 64'(pulse_cyc.size() - base), 64'd0);

    repeat (4) @(posedge clk); #1;
    check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
